// File: rtl/sram_1p_access_ctrl.sv
// Access controller for a single-port, segment-masked SRAM macro: zero-fill after reset,
// round-robin write/read arbitration, and a backpressured response register for read data.
module sram_1p_access_ctrl #(
    parameter int DEPTH         = 256,
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 192,
    parameter int SEGS          = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [SEGS-1:0]   w_mask,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [SEGS-1:0]   sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              last_wr_q, last_wr_d;   // 1 = last grant was a write
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              rd_ok, grant_wr, grant_rd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            rd_pend_q    <= 1'b0;
            last_wr_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pend_q    <= rd_pend_d;
            last_wr_q    <= last_wr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_pend_d    = 1'b0;
        last_wr_d    = last_wr_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        sram_en      = 1'b0;
        sram_wmode   = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;
        // A read may issue only if its data will have somewhere to land.
        rd_ok        = !rd_pend_q && (!resp_valid_q || resp_ready);

        case (state_q)
            ST_INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = '1;
                sram_addr  = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (w_valid && r_valid && rd_ok) begin
                    grant_rd = last_wr_q;
                    grant_wr = !last_wr_q;
                end else if (w_valid) begin
                    grant_wr = 1'b1;
                end else if (r_valid && rd_ok) begin
                    grant_rd = 1'b1;
                end
            end
        endcase

        if (grant_wr) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wmask = w_mask;
            sram_wdata = w_data;
            last_wr_d  = 1'b1;
        end else if (grant_rd) begin
            sram_en    = 1'b1;
            sram_addr  = r_addr;
            rd_pend_d  = 1'b1;
            last_wr_d  = 1'b0;
        end

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
        // Macro data is valid the cycle after the read enable; capture it then.
        if (rd_pend_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = sram_rdata;
        end
    end

    assign w_ready    = grant_wr;
    assign r_ready    = grant_rd;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign init_done  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sram_1p_access_ctrl.sv
// Scoreboard bench for sram_1p_access_ctrl with a behavioural masked single-port SRAM.
module tb_sram_1p_access_ctrl;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         w_valid, w_ready, r_valid, r_ready;
    logic [7:0]   w_addr, r_addr, sram_addr;
    logic [7:0]   w_mask, sram_wmask;
    logic [191:0] w_data, resp_data, sram_wdata, sram_rdata;
    logic         resp_valid, resp_ready, init_done, sram_en, sram_wmode;

    logic [191:0] exp_q[$];
    logic [191:0] mem [256];
    int           total_cnt = 0;
    int           pass_cnt  = 0;

    localparam logic [191:0] EXP_A5 = {24{8'hA5}};
    localparam logic [191:0] EXP_M1 = {{21{8'hA5}}, 24'hFFFFFF};
    localparam logic [191:0] EXP_5A = {24{8'h5A}};

    sram_1p_access_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // Macro model: masked write, registered read.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int s = 0; s < 8; s++)
                    if (sram_wmask[s]) mem[sram_addr][s*24 +: 24] <= sram_wdata[s*24 +: 24];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s = %h", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every handshake pops one expected value.
    initial begin
        logic [191:0] e;
        forever begin
            @(negedge clock);
            if (reset_n && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_resp: got %h expected none", resp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_init();
        int cyc = 0, writes = 0, bad = 0, stale = 0;
        while (cyc < 400) begin
            @(negedge clock);
            if (init_done) break;
            if (resp_valid) stale++;
            if (sram_en && sram_wmode && sram_wmask == 8'hFF && sram_wdata == '0 &&
                sram_addr == writes[7:0])
                writes++;
            else
                bad++;
            @(posedge clock);
            cyc++;
        end
        chk("init_cycles", 192'(cyc), 192'(256));
        chk("init_writes", 192'(writes), 192'(256));
        chk("init_bad_writes", 192'(bad), 192'(0));
        chk("init_no_stale_resp", 192'(stale), 192'(0));
        @(posedge clock); #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] m, input logic [191:0] d);
        int n = 0;
        w_addr = a; w_mask = m; w_data = d; w_valid = 1'b1;
        do begin @(negedge clock); n++; end while (!w_ready && n < 50);
        if (!w_ready) begin
            total_cnt++;
            $display("FAIL write_accept_timeout: got no w_ready expected accept");
        end
        @(posedge clock); #1;
        w_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [191:0] e);
        int n = 0;
        r_addr = a; r_valid = 1'b1;
        do begin @(negedge clock); n++; end while (!r_ready && n < 50);
        if (r_ready) exp_q.push_back(e);
        else begin
            total_cnt++;
            $display("FAIL read_accept_timeout: got no r_ready expected accept");
        end
        @(posedge clock); #1;
        r_valid = 1'b0;
    endtask

    initial begin
        string exp_g = "WRWRWRWR";
        logic [7:0] g;
        int wi, ri, n;
        logic prev_rd;
        reset_n = 1'b0; w_valid = 0; r_valid = 0; resp_ready = 1'b1;
        w_addr = 0; w_mask = 0; w_data = 0; r_addr = 0;

        // 1. reset values, zero-fill, read back a cleared entry
        repeat (3) @(posedge clock); #1;
        chk("rst_w_ready", 192'(w_ready), 0);
        chk("rst_r_ready", 192'(r_ready), 0);
        chk("rst_resp_valid", 192'(resp_valid), 0);
        chk("rst_init_done", 192'(init_done), 0);
        chk("rst_resp_data", resp_data, 0);
        reset_n = 1'b1;
        wait_init();
        do_read(8'h7F, '0);
        repeat (3) @(posedge clock); #1;

        // 2. full write then read, latency 2
        do_write(8'h10, 8'hFF, EXP_A5);
        do_read(8'h10, EXP_A5);
        chk("lat_t1_resp_valid", 192'(resp_valid), 0);
        @(posedge clock); #1;
        chk("lat_t2_resp_valid", 192'(resp_valid), 1);
        repeat (2) @(posedge clock); #1;

        // 3. single-segment masked write
        do_write(8'h10, 8'h01, {24{8'hFF}});
        do_read(8'h10, EXP_M1);
        repeat (4) @(posedge clock); #1;

        // 4. both ports valid: alternating grants, read gating
        wi = 0; ri = 0; prev_rd = 1'b0;
        for (int c = 0; c < 8; c++) begin
            w_valid = 1'b1; r_valid = 1'b1; w_mask = 8'hFF;
            w_addr = 8'h20 + 8'(wi); w_data = {24{8'(8'h30 + wi)}};
            r_addr = 8'h20 + 8'(ri);
            @(negedge clock);
            g = w_ready ? "W" : (r_ready ? "R" : "-");
            chk($sformatf("grant_%0d", c), 192'(g), 192'(exp_g[c]));
            if (r_ready) begin
                chk("rd_gate", 192'(prev_rd || (resp_valid && !resp_ready)), 0);
                exp_q.push_back({24{8'(8'h30 + ri)}});
            end
            prev_rd = r_ready;
            if (w_ready) wi++;
            if (r_ready) ri++;
            @(posedge clock); #1;
        end
        w_valid = 1'b0; r_valid = 1'b0;
        repeat (4) @(posedge clock); #1;

        // 5. held response under backpressure
        resp_ready = 1'b0;
        do_read(8'h10, EXP_M1);
        n = 0;
        do begin @(negedge clock); n++; end while (!resp_valid && n < 20);
        chk("bp_resp_valid", 192'(resp_valid), 1);
        @(posedge clock); #1;
        w_valid = 1'b1; w_addr = 8'h40; w_mask = 8'hFF; w_data = EXP_5A;
        r_valid = 1'b1; r_addr = 8'h40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("bp_hold_valid", 192'(resp_valid), 1);
            chk("bp_hold_data", resp_data, EXP_M1);
            chk("bp_r_ready", 192'(r_ready), 0);
            chk("bp_w_ready", 192'(w_ready), 1);
            @(posedge clock); #1;
        end
        w_valid = 1'b0; resp_ready = 1'b1;
        exp_q.push_back(EXP_5A);
        @(negedge clock);
        chk("bp_release_r_ready", 192'(r_ready), 1);
        @(posedge clock); #1;
        r_valid = 1'b0;
        repeat (4) @(posedge clock); #1;

        // 6. reset with a read in flight
        do_read(8'h7F, '0);
        reset_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 192'(resp_valid), 0);
        chk("midrst_init_done", 192'(init_done), 0);
        exp_q.delete();
        repeat (3) @(posedge clock); #1;
        reset_n = 1'b1;
        wait_init();
        do_read(8'h10, '0);
        repeat (5) @(posedge clock); #1;
        chk("scoreboard_empty", 192'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
